// File: rtl/io_pkg.sv
// Shared constants for the switch/button debounce front end.
package io_pkg;

   localparam int DEFAULT_SW_WIDTH        = 16;
   localparam int DEFAULT_DEBOUNCE_CYCLES = 200000;
   localparam int CNT_WIDTH               = 20;

endpackage

// File: rtl/debounce_cell.sv
// One debounce channel: two-flop synchroniser, previous sample, saturating
// stability counter and the accepted (stable) value for a WIDTH-bit bus.
module debounce_cell
   import io_pkg::*;
#(
   parameter int WIDTH           = 1,
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] raw,
   output logic [WIDTH-1:0] stable
);

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

   logic [WIDTH-1:0]     meta;
   logic [WIDTH-1:0]     sync;
   logic [WIDTH-1:0]     prev;
   logic [CNT_WIDTH-1:0] count;

   // The whole bus is one channel, so a bounce on any bit restarts the count
   // and all bits are accepted together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta   <= '0;
         sync   <= '0;
         prev   <= '0;
         count  <= '0;
         stable <= '0;
      end else begin
         meta <= raw;
         sync <= meta;
         prev <= sync;
         if (sync != prev) begin
            count <= '0;
         end else if (count != CNT_MAX) begin
            count <= count + CNT_WIDTH'(1);
         end else if (stable != sync) begin
            stable <= sync;
         end
      end
   end

endmodule

// File: rtl/switch_debounce.sv
// Debounced switch bus plus a confirmation button that latches a snapshot of
// the switches on each accepted press, held until the CPU acknowledges it.
module switch_debounce
   import io_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int SW_WIDTH        = DEFAULT_SW_WIDTH
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [SW_WIDTH-1:0] switch_raw,
   input  logic                confirm_raw,
   input  logic                ack,
   output logic [SW_WIDTH-1:0] switch_input,
   output logic                confirmation,
   output logic                confirm_pulse,
   output logic [SW_WIDTH-1:0] switch_snapshot,
   output logic                overrun
);

   logic btn_stable;
   logic btn_stable_d;
   logic press;

   debounce_cell #(
      .WIDTH           (SW_WIDTH),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_switch_cell (
      .clk    (clk),
      .rst    (rst),
      .raw    (switch_raw),
      .stable (switch_input)
   );

   debounce_cell #(
      .WIDTH           (1),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_button_cell (
      .clk    (clk),
      .rst    (rst),
      .raw    (confirm_raw),
      .stable (btn_stable)
   );

   // Only the rising edge of the debounced button counts; releases are silent.
   assign press         = btn_stable & ~btn_stable_d;
   assign confirm_pulse = press;

   // A press beats a simultaneous ack: confirmation stays set, overrun drops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         btn_stable_d    <= 1'b0;
         confirmation    <= 1'b0;
         switch_snapshot <= '0;
         overrun         <= 1'b0;
      end else begin
         btn_stable_d <= btn_stable;
         if (press) begin
            confirmation    <= 1'b1;
            switch_snapshot <= switch_input;
            if (ack && confirmation) begin
               overrun <= 1'b0;
            end else begin
               overrun <= overrun | confirmation;
            end
         end else if (ack && confirmation) begin
            confirmation <= 1'b0;
            overrun      <= 1'b0;
         end
      end
   end

endmodule
